// File: rtl/fighter_action_sequencer.sv
// Per-player fighter action sequencer: synchronises and debounces the controller pins,
// then steps a frame-timed action state machine with a one-entry press buffer.
module fighter_action_sequencer #(
    parameter int unsigned DB_CYCLES      = 2048,
    parameter int unsigned ATK_WINDUP     = 3,
    parameter int unsigned ATK_ACTIVE     = 2,
    parameter int unsigned ATK_RECOVER    = 6,
    parameter int unsigned PARRY_ACTIVE   = 4,
    parameter int unsigned PARRY_RECOVER  = 8,
    parameter int unsigned JUMP_FRAMES    = 20,
    parameter int unsigned HITSTUN_FRAMES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       left_l,
    input  logic       right_l,
    input  logic       up_l,
    input  logic       down_l,
    input  logic       attack_l,
    input  logic       parry_l,
    input  logic       hit_in,
    output logic [3:0] state_code,
    output logic [1:0] move_dir,
    output logic       crouch,
    output logic       hitbox_active,
    output logic       parry_active,
    output logic       busy,
    output logic       action_start,
    output logic       parry_success
);

    localparam int unsigned NPIN   = 6;
    localparam int unsigned DB_LIM = (DB_CYCLES == 0) ? 1 : DB_CYCLES;
    localparam int unsigned DBW    = $clog2(DB_LIM + 1);
    localparam int unsigned FW     = 16;

    localparam int unsigned P_LEFT  = 0;
    localparam int unsigned P_RIGHT = 1;
    localparam int unsigned P_UP    = 2;
    localparam int unsigned P_DOWN  = 3;
    localparam int unsigned P_ATK   = 4;
    localparam int unsigned P_PARRY = 5;

    typedef enum logic [3:0] {
        S_IDLE          = 4'd0,
        S_WALK          = 4'd1,
        S_CROUCH        = 4'd2,
        S_JUMP          = 4'd3,
        S_ATK_WINDUP    = 4'd4,
        S_ATK_ACTIVE    = 4'd5,
        S_ATK_RECOVER   = 4'd6,
        S_PARRY         = 4'd7,
        S_PARRY_RECOVER = 4'd8,
        S_HITSTUN       = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        B_NONE  = 2'd0,
        B_ATK   = 2'd1,
        B_PARRY = 2'd2
    } buf_t;

    function automatic logic [FW-1:0] load_val(input int unsigned p);
        return (p == 0) ? FW'(1) : FW'(p);
    endfunction

    function automatic logic is_busy(input state_t s);
        return !(s inside {S_IDLE, S_WALK, S_CROUCH});
    endfunction

    logic [NPIN-1:0]          pins;
    logic [NPIN-1:0]          sync1;
    logic [NPIN-1:0]          sync2;
    logic [NPIN-1:0]          db;
    logic [NPIN-1:0]          db_nxt;
    logic [NPIN-1:0][DBW-1:0] db_cnt;
    logic [NPIN-1:0][DBW-1:0] db_cnt_nxt;
    logic                     attack_press;
    logic                     parry_press;

    logic left_held;
    logic right_held;
    logic up_held;
    logic down_held;

    state_t        state;
    state_t        state_nxt;
    logic [FW-1:0] frames;
    logic [FW-1:0] frames_nxt;
    buf_t          buffer;
    buf_t          buffer_nxt;
    buf_t          buf_stored;
    logic          success_nxt;
    logic          free_eval;
    logic          expired;
    logic          take_parry;
    logic          take_attack;

    assign pins = {parry_l, attack_l, down_l, up_l, right_l, left_l};

    assign left_held  = ~db[P_LEFT];
    assign right_held = ~db[P_RIGHT];
    assign up_held    = ~db[P_UP];
    assign down_held  = ~db[P_DOWN];

    // Debounce: a level flips only after DB_LIM consecutive disagreeing synced samples.
    always_comb begin
        db_nxt     = db;
        db_cnt_nxt = '0;
        for (int i = 0; i < NPIN; i++) begin
            if (sync2[i] != db[i]) begin
                if (db_cnt[i] == DBW'(DB_LIM - 1)) begin
                    db_nxt[i] = sync2[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1        <= '1;
            sync2        <= '1;
            db           <= '1;
            db_cnt       <= '0;
            attack_press <= 1'b0;
            parry_press  <= 1'b0;
        end else begin
            sync1        <= pins;
            sync2        <= sync1;
            db           <= db_nxt;
            db_cnt       <= db_cnt_nxt;
            attack_press <= db[P_ATK] & ~db_nxt[P_ATK];
            parry_press  <= db[P_PARRY] & ~db_nxt[P_PARRY];
        end
    end

    // Next-state, frame counter and press buffer.
    always_comb begin
        state_nxt   = state;
        frames_nxt  = frames;
        buffer_nxt  = buffer;
        success_nxt = 1'b0;
        free_eval   = 1'b0;

        // Presses while busy (outside hitstun) land in the buffer, latest wins.
        buf_stored = buffer;
        if (is_busy(state) && state != S_HITSTUN) begin
            if (parry_press) begin
                buf_stored = B_PARRY;
            end else if (attack_press) begin
                buf_stored = B_ATK;
            end
        end
        buffer_nxt  = buf_stored;
        take_parry  = (buf_stored == B_PARRY) || ((buf_stored == B_NONE) && parry_press);
        take_attack = (buf_stored == B_ATK) || ((buf_stored == B_NONE) && attack_press);
        expired     = frame_tick && (frames < FW'(2));

        if (hit_in && state != S_PARRY) begin
            state_nxt  = S_HITSTUN;
            frames_nxt = load_val(HITSTUN_FRAMES);
            buffer_nxt = B_NONE;
        end else begin
            case (state)
                S_IDLE, S_WALK, S_CROUCH: begin
                    free_eval = 1'b1;
                end
                S_JUMP, S_ATK_RECOVER, S_PARRY_RECOVER, S_HITSTUN: begin
                    if (expired) begin
                        free_eval = 1'b1;
                    end else if (frame_tick) begin
                        frames_nxt = frames - FW'(1);
                    end
                end
                S_ATK_WINDUP: begin
                    if (expired) begin
                        state_nxt  = S_ATK_ACTIVE;
                        frames_nxt = load_val(ATK_ACTIVE);
                    end else if (frame_tick) begin
                        frames_nxt = frames - FW'(1);
                    end
                end
                S_ATK_ACTIVE: begin
                    if (expired) begin
                        state_nxt  = S_ATK_RECOVER;
                        frames_nxt = load_val(ATK_RECOVER);
                    end else if (frame_tick) begin
                        frames_nxt = frames - FW'(1);
                    end
                end
                S_PARRY: begin
                    success_nxt = hit_in;
                    if (expired) begin
                        state_nxt  = S_PARRY_RECOVER;
                        frames_nxt = load_val(PARRY_RECOVER);
                    end else if (frame_tick) begin
                        frames_nxt = frames - FW'(1);
                    end
                end
                default: begin
                    state_nxt  = S_IDLE;
                    frames_nxt = '0;
                    buffer_nxt = B_NONE;
                end
            endcase

            if (free_eval) begin
                buffer_nxt = B_NONE;
                if (take_parry) begin
                    state_nxt  = S_PARRY;
                    frames_nxt = load_val(PARRY_ACTIVE);
                end else if (take_attack) begin
                    state_nxt  = S_ATK_WINDUP;
                    frames_nxt = load_val(ATK_WINDUP);
                end else if (up_held) begin
                    state_nxt  = S_JUMP;
                    frames_nxt = load_val(JUMP_FRAMES);
                end else if (down_held) begin
                    state_nxt = S_CROUCH;
                end else if (left_held || right_held) begin
                    state_nxt = S_WALK;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
        end
    end

    // State register; outputs decoded from the next state so they move with state_code.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            frames        <= '0;
            buffer        <= B_NONE;
            state_code    <= 4'd0;
            move_dir      <= 2'b00;
            crouch        <= 1'b0;
            hitbox_active <= 1'b0;
            parry_active  <= 1'b0;
            busy          <= 1'b0;
            action_start  <= 1'b0;
            parry_success <= 1'b0;
        end else begin
            state         <= state_nxt;
            frames        <= frames_nxt;
            buffer        <= buffer_nxt;
            state_code    <= state_nxt;
            move_dir      <= (state_nxt == S_WALK) ? (left_held ? 2'b01 : 2'b10) : 2'b00;
            crouch        <= (state_nxt == S_CROUCH);
            hitbox_active <= (state_nxt == S_ATK_ACTIVE);
            parry_active  <= (state_nxt == S_PARRY);
            busy          <= is_busy(state_nxt);
            action_start  <= (state_nxt == S_ATK_WINDUP || state_nxt == S_PARRY) && (state_nxt != state);
            parry_success <= success_nxt;
        end
    end

endmodule
